// File: rtl/ttlock_key_sequencer.sv
// Brute-force key-candidate driver for the TTLock locked netlist: steps keyinput through a
// range, samples lock_out after a settle delay and compares it with the oracle output.
module ttlock_key_sequencer #(
    parameter int KEY_W  = 32,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             stop_on_match,
    input  logic [KEY_W-1:0] key_base,
    input  logic [31:0]      key_num,
    input  logic             lock_out,
    input  logic             oracle_out,
    output logic [KEY_W-1:0] keyinput,
    output logic             busy,
    output logic             done,
    output logic             found,
    output logic [KEY_W-1:0] found_key,
    output logic [31:0]      match_cnt,
    output logic [31:0]      tested_cnt
);

    typedef enum logic [1:0] {IDLE, WAIT, CHECK} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t           state, state_nxt;
    logic [3:0]       settle_cnt, settle_cnt_nxt;
    logic [31:0]      rem, rem_nxt;
    logic             stop_mode, stop_mode_nxt;
    logic [KEY_W-1:0] keyinput_nxt;
    logic             busy_nxt, done_nxt, found_nxt;
    logic [KEY_W-1:0] found_key_nxt;
    logic [31:0]      match_cnt_nxt, tested_cnt_nxt;
    logic             match;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            rem        <= '0;
            stop_mode  <= 1'b0;
            keyinput   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            found      <= 1'b0;
            found_key  <= '0;
            match_cnt  <= '0;
            tested_cnt <= '0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_cnt_nxt;
            rem        <= rem_nxt;
            stop_mode  <= stop_mode_nxt;
            keyinput   <= keyinput_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            found      <= found_nxt;
            found_key  <= found_key_nxt;
            match_cnt  <= match_cnt_nxt;
            tested_cnt <= tested_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        settle_cnt_nxt = settle_cnt;
        rem_nxt        = rem;
        stop_mode_nxt  = stop_mode;
        keyinput_nxt   = keyinput;
        busy_nxt       = busy;
        done_nxt       = done;
        found_nxt      = found;
        found_key_nxt  = found_key;
        match_cnt_nxt  = match_cnt;
        tested_cnt_nxt = tested_cnt;
        match          = (lock_out == oracle_out);

        case (state)
            IDLE: begin
                if (start && !abort) begin
                    stop_mode_nxt  = stop_on_match;
                    done_nxt       = 1'b0;
                    found_nxt      = 1'b0;
                    found_key_nxt  = '0;
                    match_cnt_nxt  = '0;
                    tested_cnt_nxt = '0;
                    if (key_num == 32'd0) begin
                        // Empty run completes in place; keyinput keeps its old value.
                        done_nxt = 1'b1;
                    end else begin
                        keyinput_nxt   = key_base;
                        rem_nxt        = key_num;
                        busy_nxt       = 1'b1;
                        settle_cnt_nxt = '0;
                        state_nxt      = WAIT;
                    end
                end
            end
            WAIT: begin
                if (abort) begin
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else if (settle_cnt == SETTLE_LAST) begin
                    state_nxt = CHECK;
                end else begin
                    settle_cnt_nxt = settle_cnt + 4'd1;
                end
            end
            CHECK: begin
                // Abort discards this sample so status reflects only completed checks.
                if (abort) begin
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    tested_cnt_nxt = tested_cnt + 32'd1;
                    rem_nxt        = rem - 32'd1;
                    if (match) begin
                        match_cnt_nxt = sat_inc(match_cnt);
                        if (!found) begin
                            found_nxt     = 1'b1;
                            found_key_nxt = keyinput;
                        end
                    end
                    if (rem == 32'd1 || (match && stop_mode)) begin
                        busy_nxt  = 1'b0;
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        keyinput_nxt   = keyinput + KEY_W'(1);
                        settle_cnt_nxt = '0;
                        state_nxt      = WAIT;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ttlock_key_sequencer.sv
// Directed bench for ttlock_key_sequencer: run results are queued at start and compared at done;
// the locked netlist is stood in for by a match table or a behavioural TTLock model.
module tb_ttlock_key_sequencer;

    localparam int S = 2;
    localparam logic [31:0] PROT = 32'h5A5A_C3C3;

    typedef struct {
        logic        f;
        logic [31:0] k;
        logic [31:0] m;
        logic [31:0] t;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        stop_on_match = 1'b0;
    logic [31:0] key_base = '0;
    logic [31:0] key_num = '0;
    logic        lock_out;
    logic        oracle_out = 1'b0;
    logic [31:0] keyinput;
    logic        busy, done, found;
    logic [31:0] found_key, match_cnt, tested_cnt;

    logic        mode = 1'b0;
    logic [31:0] match_a = '0, match_b = '0, pi = '0;

    int checks = 0;
    int errors = 0;

    exp_t        exp_q[$];
    logic [31:0] key_q[$];

    ttlock_key_sequencer #(.KEY_W(32), .SETTLE(S)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .stop_on_match(stop_on_match), .key_base(key_base), .key_num(key_num),
        .lock_out(lock_out), .oracle_out(oracle_out), .keyinput(keyinput),
        .busy(busy), .done(done), .found(found), .found_key(found_key),
        .match_cnt(match_cnt), .tested_cnt(tested_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic orig_fn(input logic [31:0] p);
        return ^p;
    endfunction

    // TTLock: protected cube flipped by the stripped circuit, restored when key equals input.
    function automatic logic ttl_fn(input logic [31:0] p, input logic [31:0] k);
        return orig_fn(p) ^ (p == PROT) ^ (p == k);
    endfunction

    always_comb begin
        lock_out = 1'b0;
        if (mode) lock_out = ttl_fn(pi, keyinput);
        else      lock_out = oracle_out ^ ~((keyinput == match_a) || (keyinput == match_b));
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_keyinput"}, keyinput, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_found"}, {31'd0, found}, 32'd0);
        chk({tag, "_found_key"}, found_key, 32'd0);
        chk({tag, "_match_cnt"}, match_cnt, 32'd0);
        chk({tag, "_tested_cnt"}, tested_cnt, 32'd0);
    endtask

    task automatic begin_run(input logic [31:0] base, input logic [31:0] num, input logic stop);
        key_base      = base;
        key_num       = num;
        stop_on_match = stop;
        start         = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Waits for done, checking queued keys at each candidate boundary, then scores the run.
    task automatic finish_run(input string tag);
        exp_t e;
        int   cyc;
        cyc = 0;
        chk({tag, "_busy_at_start"}, {31'd0, busy}, 32'd1);
        chk({tag, "_done_cleared"}, {31'd0, done}, 32'd0);
        while (!done && cyc < 400) begin
            if (cyc % (S + 1) == 0 && key_q.size() > 0)
                chk({tag, "_key_seq"}, keyinput, key_q.pop_front());
            tick();
            cyc++;
        end
        chk({tag, "_done_seen"}, {31'd0, done}, 32'd1);
        e = exp_q.pop_front();
        chk({tag, "_cycles"}, cyc, e.cyc);
        chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
        chk({tag, "_found"}, {31'd0, found}, {31'd0, e.f});
        chk({tag, "_found_key"}, found_key, e.k);
        chk({tag, "_match_cnt"}, match_cnt, e.m);
        chk({tag, "_tested_cnt"}, tested_cnt, e.t);
    endtask

    initial begin
        int ref_cnt;
        exp_t e;

        // Reset state
        tick();
        tick();
        check_zero("reset");
        #2 rst_n = 1'b1;
        tick();
        check_zero("post_reset");

        // Single match, stop early
        match_a = 32'h13; match_b = 32'h13;
        e = '{f: 1'b1, k: 32'h13, m: 32'd1, t: 32'd4, cyc: 4 * (S + 1)};
        exp_q.push_back(e);
        begin_run(32'h10, 32'd8, 1'b1);
        chk("single_first_key", keyinput, 32'h10);
        finish_run("single");

        // Count mode with wrap-around, started back-to-back
        match_a = 32'hFFFF_FFFF; match_b = 32'h1;
        key_q.push_back(32'hFFFF_FFFE);
        key_q.push_back(32'hFFFF_FFFF);
        key_q.push_back(32'h0);
        key_q.push_back(32'h1);
        e = '{f: 1'b1, k: 32'hFFFF_FFFF, m: 32'd2, t: 32'd4, cyc: 4 * (S + 1)};
        exp_q.push_back(e);
        begin_run(32'hFFFF_FFFE, 32'd4, 1'b0);
        finish_run("wrap");
        chk("wrap_last_key_held", keyinput, 32'h1);

        // Empty run
        begin_run(32'h777, 32'd0, 1'b0);
        chk("empty_done", {31'd0, done}, 32'd1);
        chk("empty_busy", {31'd0, busy}, 32'd0);
        chk("empty_found", {31'd0, found}, 32'd0);
        chk("empty_match_cnt", match_cnt, 32'd0);
        chk("empty_keyinput", keyinput, 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("empty_busy_stays_low", {31'd0, busy}, 32'd0);
        end

        // Abort in second WAIT cycle of candidate 3, with a colliding start
        match_a = 32'h21; match_b = 32'h21;
        begin_run(32'h20, 32'd8, 1'b0);
        for (int i = 0; i < 2 * (S + 1) + 1; i++) tick();
        abort = 1'b1; start = 1'b1; key_num = 32'd5; key_base = 32'h99;
        tick();
        abort = 1'b0; start = 1'b0;
        chk("abort_done", {31'd0, done}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_tested_cnt", tested_cnt, 32'd2);
        chk("abort_match_cnt", match_cnt, 32'd1);
        chk("abort_found_key", found_key, 32'h21);
        chk("abort_keyinput", keyinput, 32'h22);
        tick();
        chk("abort_start_ignored_done", {31'd0, done}, 32'd1);
        chk("abort_start_ignored_busy", {31'd0, busy}, 32'd0);

        // Asynchronous reset during CHECK
        match_a = 32'h40; match_b = 32'h40;
        begin_run(32'h40, 32'd8, 1'b0);
        for (int i = 0; i < 2 * (S + 1) - 1; i++) tick();
        #2 rst_n = 1'b0;
        #1 check_zero("async_reset");
        #2 rst_n = 1'b1;
        tick();
        check_zero("after_release");
        match_a = 32'h51; match_b = 32'h51;
        e = '{f: 1'b1, k: 32'h51, m: 32'd1, t: 32'd3, cyc: 3 * (S + 1)};
        exp_q.push_back(e);
        begin_run(32'h50, 32'd3, 1'b0);
        finish_run("restart");

        // No match against the behavioural TTLock netlist, protected pattern applied
        mode = 1'b1;
        pi = PROT;
        oracle_out = orig_fn(PROT);
        ref_cnt = 0;
        for (int k = 32'h100; k < 32'h110; k++)
            if (ttl_fn(PROT, 32'(k)) == orig_fn(PROT)) ref_cnt++;
        e = '{f: 1'b0, k: 32'h0, m: 32'(ref_cnt), t: 32'd16, cyc: 16 * (S + 1)};
        exp_q.push_back(e);
        begin_run(32'h100, 32'd16, 1'b0);
        finish_run("ttlock");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
